// File: rtl/sr_latch_driver.sv
// Clocked command-side driver for an asynchronous SR latch: turns accepted set/clear
// commands into fixed-width, mutually exclusive set/reset pulses and verifies the latch feedback.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_op,
    output logic cmd_ready,
    output logic set,
    output logic reset,
    input  logic q,
    input  logic q_not,
    output logic done,
    output logic err,
    output logic busy
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW    = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_W > 0) ? (GAP_W - 1) : 0);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_PULSE = 3'd1,
        ST_CHECK = 3'd2,
        ST_GAP   = 3'd3,
        ST_IDLE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          exp_q, exp_d;
    logic          user_q, user_d;
    logic          armed_q, armed_d;
    logic          err_q, err_d;
    logic          set_q, set_d;
    logic          reset_q, reset_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // State, counter and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_ZERO;
            exp_q   <= 1'b0;
            user_q  <= 1'b0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
            set_q   <= 1'b0;
            reset_q <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            user_q  <= user_d;
            armed_q <= armed_d;
            err_q   <= err_d;
            set_q   <= set_d;
            reset_q <= reset_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; armed_q marks that the INIT countdown has been loaded after reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        user_d  = user_q;
        armed_d = 1'b1;
        case (state_q)
            ST_INIT: begin
                if (!armed_q) begin
                    cnt_d = PULSE_LOAD;
                end else if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_PULSE: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (GAP_W > 0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                    exp_d   = cmd_op;
                    user_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = CNT_ZERO;
                exp_d   = 1'b0;
                user_d  = 1'b0;
                armed_d = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_q.
    always_comb begin
        set_d   = (state_d == ST_PULSE) && exp_d;
        reset_d = (state_d == ST_INIT) || ((state_d == ST_PULSE) && !exp_d);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_CHECK) && user_d;
        if (state_q == ST_CHECK) begin
            err_d = err_q | (q != exp_q) | (q_not != !exp_q);
        end else begin
            err_d = err_q;
        end
    end

    assign cmd_ready = ready_q;
    assign set       = set_q;
    assign reset     = reset_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Table-driven bench for sr_latch_driver: default-parameter DUT driving a behavioural latch,
// plus a PULSE_W=1 / GAP_W=0 instance exercised by a hand-written sequence.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic v1 = 1'b0, op1 = 1'b0, stuck = 1'b0;
    logic v2 = 1'b0, op2 = 1'b0;

    logic rdy1, set1, reset1, done1, err1, busy1, q1, qn1;
    logic rdy2, set2, reset2, done2, err2, busy2, q2, qn2;

    // Behavioural latch loads; power up holding 1 so INIT visibly clears them.
    logic lq1 = 1'b1;
    logic lq2 = 1'b1;
    always @(set1 or reset1) begin
        if (reset1) lq1 = 1'b0;
        else if (set1) lq1 = 1'b1;
    end
    always @(set2 or reset2) begin
        if (reset2) lq2 = 1'b0;
        else if (set2) lq2 = 1'b1;
    end
    assign q1  = stuck ? 1'b0 : lq1;
    assign qn1 = !lq1;
    assign q2  = lq2;
    assign qn2 = !lq2;

    sr_latch_driver #(.PULSE_W(2), .GAP_W(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_op(op1), .cmd_ready(rdy1),
        .set(set1), .reset(reset1), .q(q1), .q_not(qn1),
        .done(done1), .err(err1), .busy(busy1)
    );

    sr_latch_driver #(.PULSE_W(1), .GAP_W(0)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_op(op2), .cmd_ready(rdy2),
        .set(set2), .reset(reset2), .q(q2), .q_not(qn2),
        .done(done2), .err(err2), .busy(busy2)
    );

    // in  = {rst, cmd_valid, cmd_op, stuck}
    // exp = {set, reset, cmd_ready, done, err, busy, q, q_not}
    typedef struct packed {
        logic [3:0] in;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic [3:0] in, input logic [7:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check_inv();
        checks++;
        if ((set1 && reset1) || (set2 && reset2)) begin
            errors++;
            $display("FAIL set_and_reset t=%0t got dut1=%b%b dut2=%b%b required never both 1",
                     $time, set1, reset1, set2, reset2);
        end
    endtask

    task automatic check2(input string name, input logic [6:0] req);
        logic [6:0] act;
        act = {set2, reset2, rdy2, done2, err2, busy2, q2};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", name, act, req);
        end
    endtask

    initial begin
        // reset, INIT sequence, first set command
        add(4'b1000, 8'b0000_0110);
        add(4'b1000, 8'b0000_0110);
        add(4'b0000, 8'b0000_0110);
        add(4'b0000, 8'b0100_0101);
        add(4'b0000, 8'b0100_0101);
        add(4'b0000, 8'b0000_0101);
        add(4'b0000, 8'b0000_0101);
        add(4'b0110, 8'b0010_0001);
        add(4'b0000, 8'b1000_0110);
        add(4'b0000, 8'b1000_0110);
        add(4'b0000, 8'b0001_0110);
        add(4'b0000, 8'b0000_0110);
        // held cmd_valid, op toggled while busy
        add(4'b0100, 8'b0010_0010);
        add(4'b0110, 8'b0100_0101);
        add(4'b0110, 8'b0100_0101);
        add(4'b0110, 8'b0001_0101);
        add(4'b0110, 8'b0000_0101);
        add(4'b0110, 8'b0010_0001);
        add(4'b0100, 8'b1000_0110);
        add(4'b0100, 8'b1000_0110);
        add(4'b0000, 8'b0001_0110);
        add(4'b0000, 8'b0000_0110);
        // q stuck at 0 during a set: done still pulses, err sticks
        add(4'b0111, 8'b0010_0000);
        add(4'b0001, 8'b1000_0100);
        add(4'b0001, 8'b1000_0100);
        add(4'b0001, 8'b0001_0100);
        add(4'b0001, 8'b0000_1100);
        add(4'b0100, 8'b0010_1010);
        add(4'b0000, 8'b0100_1101);
        add(4'b0000, 8'b0100_1101);
        add(4'b0000, 8'b0001_1101);
        add(4'b0000, 8'b0000_1101);
        // rst in the first cycle of a set pulse
        add(4'b0110, 8'b0010_1001);
        add(4'b1000, 8'b1000_1110);
        add(4'b0000, 8'b0000_0110);
        add(4'b0000, 8'b0100_0101);
        add(4'b0000, 8'b0100_0101);
        add(4'b0000, 8'b0000_0101);
        add(4'b0000, 8'b0000_0101);
        add(4'b0000, 8'b0010_0001);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            logic [7:0] act;
            {rst, v1, op1, stuck} = vecs[i].in;
            @(negedge clk);
            act = {set1, reset1, rdy1, done1, err1, busy1, q1, qn1};
            checks++;
            if (act !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d got %b required %b", i, act, vecs[i].exp);
            end
            check_inv();
            @(posedge clk);
            #1;
        end

        // PULSE_W=1, GAP_W=0 instance: set in cycle 1, done in cycle 2, ready in cycle 3
        v2 = 1'b1; op2 = 1'b1;
        @(negedge clk); check2("w1_accept", 7'b0010_000); check_inv();
        @(posedge clk); #1; v2 = 1'b0; op2 = 1'b0;
        @(negedge clk); check2("w1_pulse", 7'b1000_011); check_inv();
        @(posedge clk); #1;
        @(negedge clk); check2("w1_check", 7'b0001_011); check_inv();
        @(posedge clk); #1;
        @(negedge clk); check2("w1_ready", 7'b0010_001); check_inv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
